// File: rtl/axi2apb_pkg.sv
// Shared types and helpers for the AXI-to-APB bridge: FSM states, response
// codes and the 64-bit-to-32-bit lane selection used on the write path.
package axi2apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_SETUP,
        ST_ACCESS,
        ST_WAIT_RESP
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = APB_DATA_W / 8;

    function automatic logic [APB_DATA_W-1:0] lane_data(
        input logic [2*APB_DATA_W-1:0] data,
        input logic                    lane
    );
        return lane ? data[2*APB_DATA_W-1:APB_DATA_W] : data[APB_DATA_W-1:0];
    endfunction

    function automatic logic [APB_STRB_W-1:0] lane_strb(
        input logic [2*APB_STRB_W-1:0] strb,
        input logic                    lane
    );
        return lane ? strb[2*APB_STRB_W-1:APB_STRB_W] : strb[APB_STRB_W-1:0];
    endfunction

endpackage

// File: rtl/axi2apb_cmd.sv
// Command half of the AXI-to-APB bridge: accepts one single-beat AXI command
// at a time and runs it as one APB SETUP/ACCESS transfer.
module axi2apb_cmd
    import axi2apb_pkg::*;
#(
    parameter int AXI_ID_WIDTH   = 6,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        rstn,

    input  logic [AXI_ID_WIDTH-1:0]     ARID,
    input  logic [AXI_ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]                  ARLEN,
    input  logic [2:0]                  ARSIZE,
    input  logic                        ARVALID,
    output logic                        ARREADY,

    input  logic [AXI_ID_WIDTH-1:0]     AWID,
    input  logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]                  AWLEN,
    input  logic [2:0]                  AWSIZE,
    input  logic                        AWVALID,
    output logic                        AWREADY,

    input  logic [AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                        WLAST,
    input  logic                        WVALID,
    output logic                        WREADY,

    output logic                        psel,
    output logic                        penable,
    output logic                        pwrite,
    output logic [31:0]                 paddr,
    output logic [APB_DATA_W-1:0]       pwdata,
    output logic [APB_STRB_W-1:0]       pstrb,
    input  logic                        pready,

    output logic [AXI_ID_WIDTH-1:0]     cmd_id,
    output logic                        cmd_err,
    input  logic                        finish_rd,
    input  logic                        finish_wr
);

    state_e                  state_q, state_d;
    logic                    prio_rd_q, prio_rd_d;
    logic                    first_q, first_d;
    logic                    lane_q, lane_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [31:0]             paddr_q, paddr_d;
    logic [APB_DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [APB_STRB_W-1:0]   pstrb_q, pstrb_d;
    logic [AXI_ID_WIDTH-1:0] cmd_id_q, cmd_id_d;
    logic                    cmd_err_q, cmd_err_d;

    logic idle;
    logic ar_go;
    logic aw_go;
    logic unused_addr_bits;

    // The word address drops bits [1:0]; wider AXI addresses are truncated.
    assign unused_addr_bits = ^{ARADDR, AWADDR};

    assign idle    = (state_q == ST_IDLE);
    assign ar_go   = idle && ARVALID && (!AWVALID || prio_rd_q);
    assign aw_go   = idle && AWVALID && (!ARVALID || !prio_rd_q);
    assign ARREADY = ar_go;
    assign AWREADY = aw_go;
    assign WREADY  = (state_q == ST_WDATA);

    always_comb begin
        state_d   = state_q;
        prio_rd_d = prio_rd_q;
        first_d   = first_q;
        lane_d    = lane_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        cmd_id_d  = cmd_id_q;
        cmd_err_d = cmd_err_q;

        case (state_q)
            ST_IDLE: begin
                if (ar_go) begin
                    state_d   = ST_SETUP;
                    prio_rd_d = !prio_rd_q;
                    cmd_id_d  = ARID;
                    paddr_d   = {ARADDR[31:2], 2'b00};
                    pwrite_d  = 1'b0;
                    lane_d    = ARADDR[2];
                    cmd_err_d = (ARLEN != 8'd0) || (ARSIZE > 3'd2);
                    pwdata_d  = '0;
                    pstrb_d   = '0;
                end else if (aw_go) begin
                    state_d   = ST_WDATA;
                    prio_rd_d = !prio_rd_q;
                    cmd_id_d  = AWID;
                    paddr_d   = {AWADDR[31:2], 2'b00};
                    pwrite_d  = 1'b1;
                    lane_d    = AWADDR[2];
                    cmd_err_d = (AWLEN != 8'd0) || (AWSIZE > 3'd2);
                    first_d   = 1'b1;
                end
            end
            ST_WDATA: begin
                // Only the first beat is kept; an error burst is drained to WLAST.
                if (WVALID) begin
                    if (first_q) begin
                        pwdata_d = lane_data(WDATA, lane_q);
                        pstrb_d  = cmd_err_q ? '0 : lane_strb(WSTRB, lane_q);
                        first_d  = 1'b0;
                    end
                    if (WLAST) begin
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    state_d = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                if (pwrite_q ? finish_wr : finish_rd) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        psel_d    = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d = (state_d == ST_ACCESS);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            prio_rd_q <= 1'b1;
            first_q   <= 1'b0;
            lane_q    <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            cmd_id_q  <= '0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_rd_q <= prio_rd_d;
            first_q   <= first_d;
            lane_q    <= lane_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            cmd_id_q  <= cmd_id_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    assign psel    = psel_q;
    assign penable = penable_q;
    assign pwrite  = pwrite_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;
    assign pstrb   = pstrb_q;
    assign cmd_id  = cmd_id_q;
    assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_axi2apb_cmd.sv
// Self-checking bench for axi2apb_cmd: directed vector table, hand-written
// reset/arbitration sequences and randomized commands against a command-level model.
module tb_axi2apb_cmd;

    logic        clk = 1'b0;
    logic        rstn;
    logic [5:0]  ARID, AWID;
    logic [31:0] ARADDR, AWADDR;
    logic [7:0]  ARLEN, AWLEN;
    logic [2:0]  ARSIZE, AWSIZE;
    logic        ARVALID, ARREADY, AWVALID, AWREADY;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic        WLAST, WVALID, WREADY;
    logic        psel, penable, pwrite, pready;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [5:0]  cmd_id;
    logic        cmd_err, finish_rd, finish_wr;

    always #5 clk = ~clk;

    axi2apb_cmd #(
        .AXI_ID_WIDTH  (6),
        .AXI_ADDR_WIDTH(32),
        .AXI_DATA_WIDTH(64)
    ) dut (
        .clk(clk), .rstn(rstn),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pready(pready),
        .cmd_id(cmd_id), .cmd_err(cmd_err), .finish_rd(finish_rd), .finish_wr(finish_wr)
    );

    typedef struct {
        bit          is_wr;
        logic [5:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        int          waits;
        logic [31:0] exp_paddr;
        logic [31:0] exp_pwdata;
        logic [3:0]  exp_pstrb;
        bit          exp_err;
    } vec_t;

    int tests = 0;
    int fails = 0;
    bit prio_rd_m;   // model arbiter: 1 = read wins when both channels are valid

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Command-level model: what one APB transfer should look like for a command.
    function automatic vec_t model(input vec_t v);
        int lane;
        vec_t r = v;
        lane         = (v.addr / 4) % 2;
        r.exp_err    = (v.len != 0) || (v.size > 2);
        r.exp_paddr  = v.addr - (v.addr % 4);
        r.exp_pwdata = 32'(v.wdata >> (32 * lane));
        r.exp_pstrb  = r.exp_err ? 4'h0 : 4'(v.wstrb >> (4 * lane));
        return r;
    endfunction

    task automatic idle_inputs();
        ARVALID = 0; AWVALID = 0; WVALID = 0; WLAST = 0;
        pready = 0; finish_rd = 0; finish_wr = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rstn = 1;
        prio_rd_m = 1;
    endtask

    task automatic run_cmd(input vec_t v, input bit other);
        int  f0 = fails;
        bit  grant_rd;
        @(negedge clk);
        if (v.is_wr) begin
            AWID = v.id; AWADDR = v.addr; AWLEN = v.len; AWSIZE = v.size; AWVALID = 1;
            ARID = 6'($urandom); ARADDR = $urandom; ARLEN = 0; ARSIZE = 2; ARVALID = other;
        end else begin
            ARID = v.id; ARADDR = v.addr; ARLEN = v.len; ARSIZE = v.size; ARVALID = 1;
            AWID = 6'($urandom); AWADDR = $urandom; AWLEN = 0; AWSIZE = 2; AWVALID = other;
        end
        grant_rd = other ? prio_rd_m : !v.is_wr;
        #1;
        chk("arready_grant", ARREADY, grant_rd);
        chk("awready_grant", AWREADY, !grant_rd);
        chk("wready_idle", WREADY, 0);
        prio_rd_m = !prio_rd_m;
        @(posedge clk);
        if (v.is_wr) begin
            for (int b = 0; b <= int'(v.len); b++) begin
                @(negedge clk);
                ARVALID = 0; AWVALID = 0;
                WVALID = 1;
                WDATA  = (b == 0) ? v.wdata : {$urandom, $urandom};
                WSTRB  = (b == 0) ? v.wstrb : 8'($urandom);
                WLAST  = (b == int'(v.len));
                #1;
                chk("wready_beat", WREADY, 1);
                @(posedge clk);
            end
        end
        // SETUP phase: exactly one cycle after the last handshake
        @(negedge clk);
        idle_inputs();
        #1;
        chk("setup_psel_pen", {psel, penable}, 2'b10);
        chk("paddr", paddr, v.exp_paddr);
        chk("pwrite", pwrite, v.is_wr);
        chk("cmd_id", cmd_id, v.id);
        chk("cmd_err", cmd_err, v.exp_err);
        if (v.is_wr) begin
            chk("pwdata", pwdata, v.exp_pwdata);
            chk("pstrb", pstrb, v.exp_pstrb);
        end
        for (int k = 0; k <= v.waits; k++) begin
            @(negedge clk);
            pready = (k == v.waits);
            #1;
            chk("access_psel_pen", {psel, penable}, 2'b11);
            chk("access_paddr_hold", paddr, v.exp_paddr);
            if (v.is_wr) chk("access_pwdata_hold", pwdata, v.exp_pwdata);
        end
        @(negedge clk);
        pready = 0;
        if (v.is_wr) finish_rd = 1; else finish_wr = 1;
        ARVALID = 1; AWVALID = 1;
        #1;
        chk("wait_resp_psel_pen", {psel, penable}, 2'b00);
        chk("wait_resp_cmd_id", cmd_id, v.id);
        chk("wait_resp_cmd_err", cmd_err, v.exp_err);
        chk("wait_resp_no_accept", {ARREADY, AWREADY}, 2'b00);
        ARVALID = 0; AWVALID = 0;
        @(negedge clk);
        finish_rd = 0; finish_wr = 0;
        ARVALID = 1;
        #1;
        chk("ignore_other_finish", ARREADY, 0);
        ARVALID = 0;
        if (v.is_wr) finish_wr = 1; else finish_rd = 1;
        @(negedge clk);
        finish_rd = 0; finish_wr = 0;
        ARVALID = 1;
        #1;
        chk("ready_after_finish", ARREADY, 1);
        ARVALID = 0;
        if (fails != f0) do_reset();
    endtask

    vec_t tbl[6];
    vec_t v;

    initial begin
        rstn = 0;
        ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0;
        AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0;
        WDATA = 0; WSTRB = 0;
        idle_inputs();
        prio_rd_m = 1;

        //          wr  id     addr           len   size  wdata                    wstrb  w  paddr          pwdata         pstrb err
        tbl[0] = '{0, 6'd5,  32'h0000_1004, 8'd0, 3'd2, 64'h0,                   8'h00, 0, 32'h0000_1004, 32'h0,         4'h0, 0};
        tbl[1] = '{1, 6'd3,  32'h0000_2004, 8'd0, 3'd2, 64'hAABBCCDD_11223344,   8'hF0, 0, 32'h0000_2004, 32'hAABBCCDD,  4'hF, 0};
        tbl[2] = '{1, 6'd7,  32'h0000_0400, 8'd0, 3'd2, 64'hCAFEBABE_DEADBEEF,   8'h3C, 3, 32'h0000_0400, 32'hDEADBEEF,  4'hC, 0};
        tbl[3] = '{1, 6'd1,  32'h0000_2000, 8'd3, 3'd2, 64'h55667788_99AABBCC,   8'hFF, 1, 32'h0000_2000, 32'h99AABBCC,  4'h0, 1};
        tbl[4] = '{0, 6'h3F, 32'hFFFF_FFFF, 8'd0, 3'd3, 64'h0,                   8'h00, 2, 32'hFFFF_FFFC, 32'h0,         4'h0, 1};
        tbl[5] = '{1, 6'd9,  32'h0000_0017, 8'd0, 3'd1, 64'h01234567_89ABCDEF,   8'hA5, 0, 32'h0000_0014, 32'h01234567,  4'hA, 0};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_psel_pen", {psel, penable}, 2'b00);
        chk("rst_pwrite_err", {pwrite, cmd_err}, 2'b00);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata_pstrb", {pwdata, pstrb}, 0);
        chk("rst_cmd_id", cmd_id, 0);
        chk("rst_wready", WREADY, 0);
        @(negedge clk);
        rstn = 1;

        foreach (tbl[i]) run_cmd(tbl[i], 0);

        // Reset while an ACCESS is stalled on pready
        @(negedge clk);
        ARID = 6'd12; ARADDR = 32'h3008; ARLEN = 0; ARSIZE = 2; ARVALID = 1;
        @(negedge clk);
        ARVALID = 0;
        @(negedge clk);
        #1;
        chk("abort_in_access", {psel, penable}, 2'b11);
        rstn = 0;
        #1;
        chk("abort_async_psel_pen", {psel, penable}, 2'b00);
        @(negedge clk);
        rstn = 1;
        prio_rd_m = 1;
        @(negedge clk);
        ARVALID = 1; AWVALID = 1;
        #1;
        chk("abort_arready", ARREADY, 1);
        chk("abort_awready", AWREADY, 0);
        chk("abort_cmd_id", cmd_id, 0);
        chk("abort_paddr", paddr, 0);
        ARVALID = 0; AWVALID = 0;

        // Both channels valid back to back: read first, then write
        v = model('{0, 6'd21, 32'h0000_5000, 8'd0, 3'd2, 64'h0, 8'h0, 0, 0, 0, 0, 0});
        run_cmd(v, 1);
        v = model('{1, 6'd22, 32'h0000_6004, 8'd0, 3'd2, 64'h12345678_9ABCDEF0, 8'hFF, 1, 0, 0, 0, 0});
        run_cmd(v, 1);

        for (int n = 0; n < 40; n++) begin
            bit other;
            other    = 1'($urandom);
            v.is_wr  = other ? !prio_rd_m : 1'($urandom);
            v.id     = 6'($urandom);
            v.addr   = $urandom;
            v.len    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'd0;
            v.size   = 3'($urandom_range(0, 3));
            v.wdata  = {$urandom, $urandom};
            v.wstrb  = 8'($urandom);
            v.waits  = $urandom_range(0, 3);
            v = model(v);
            run_cmd(v, other);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi2apb_cmd.md
Name: axi2apb_cmd

Overview:
- Command and APB-initiator half of the AXI-to-APB bridge.
- Accepts one AXI read (AR) or write (AW+W) command at a time, converts it into a single APB SETUP/ACCESS transfer, and exports cmd_id/cmd_err to the R and B response blocks.
- Holds off the next command until the response block signals completion (finish_rd/finish_wr).
- Supports single-beat AXI transactions only; anything else is flagged as an error and still completed as one harmless APB transfer.

Parameters:
- AXI_ID_WIDTH, 6, AXI ID width.
- AXI_ADDR_WIDTH, 32, AXI address width; the APB address is the low 32 bits.
- AXI_DATA_WIDTH, 64, AXI data width; fixed at 64 (two 32-bit APB lanes).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- ARID  in  AXI_ID_WIDTH  read ID
- ARADDR  in  AXI_ADDR_WIDTH  read address
- ARLEN  in  8  read burst length-1
- ARSIZE  in  3  read beat size
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- AWID  in  AXI_ID_WIDTH  write ID
- AWADDR  in  AXI_ADDR_WIDTH  write address
- AWLEN  in  8  write burst length-1
- AWSIZE  in  3  write beat size
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- WDATA  in  64  write data
- WSTRB  in  8  write strobes
- WLAST  in  1  last write beat
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  32  APB address
- pwdata  out  32  APB write data
- pstrb  out  4  APB write strobes
- pready  in  1  APB ready
- cmd_id  out  AXI_ID_WIDTH  ID of the current command
- cmd_err  out  1  current command is unsupported
- finish_rd  in  1  R response accepted (RVALID&RREADY&RLAST)
- finish_wr  in  1  B response accepted (BVALID&BREADY)

Behaviour:
- Reset (rstn low, asynchronous): state IDLE; psel, penable, pwrite, cmd_err = 0; paddr, pwdata, pstrb, cmd_id = 0; prio = read-first.
- States: IDLE, WDATA, SETUP, ACCESS, WAIT_RESP.
- IDLE:
  - ARREADY and AWREADY are combinational: high only in IDLE and only for the granted channel.
  - If only one of ARVALID/AWVALID is high, that channel is granted.
  - If both are high, the grant follows prio, and prio toggles after every accepted command (round-robin).
  - WREADY = 0 in IDLE.
- On command accept (cycle N), register:
  - cmd_id
  - paddr = {addr[31:2], 2'b00}
  - pwrite
  - lane select = addr[2]
  - cmd_err = (LEN != 0) | (SIZE > 2)
- Read accept: next state SETUP.
- Write accept: next state WDATA.
- WDATA:
  - WREADY = 1.
  - On each W handshake: if this is the first beat, capture pwdata = lane ? WDATA[63:32] : WDATA[31:0] and pstrb = lane ? WSTRB[7:4] : WSTRB[3:0]; forced pstrb = 0 if cmd_err.
  - Later beats are discarded.
  - Leave WDATA on a handshake with WLAST = 1, going to SETUP. An error burst therefore drains all beats.
- SETUP: psel = 1, penable = 0, exactly one cycle, then ACCESS.
- ACCESS:
  - psel = 1, penable = 1.
  - paddr/pwrite/pwdata/pstrb stay stable from SETUP until pready.
  - On pready = 1, go to WAIT_RESP with psel = penable = 0 on the next cycle.
  - Wait states are unbounded.
- WAIT_RESP: cmd_id/cmd_err held stable. Return to IDLE on finish_rd (read) or finish_wr (write); the other finish input is ignored.
- Latency (read, pready tied high): AR handshake at N, SETUP N+1, ACCESS N+2, WAIT_RESP N+3. ARREADY is high again in the cycle after finish_rd.
- Error commands still perform one APB transfer (writes with pstrb = 0) so the response blocks capture on the APB completion and report SLVERR via cmd_err.
- Only one command is in flight; no address or data buffering beyond the current command.
- Reset asserted mid-transfer aborts immediately to IDLE with psel = 0; no completion is generated.

Decomposition:
- Package axi2apb_pkg: state enum; RESP_OK/SLVERR/DECERR constants; APB data width 32; lane-select helper function.
- No sub-module; the arbiter is a single prio flop inside the block.

Test Plan:
- Read ARADDR = 0x1004, ARID = 5, ARLEN = 0, ARSIZE = 2, pready high -> paddr = 0x1004, pwrite = 0; SETUP at N+1, ACCESS at N+2; cmd_id = 5, cmd_err = 0; ARREADY low until the cycle after finish_rd.
- Write AWADDR = 0x2004, WDATA = 0xAABBCCDD_11223344, WSTRB = 0xF0 -> pwdata = 0xAABBCCDD, pstrb = 0xF, pwrite = 1; returns to IDLE after finish_wr.
- pready low for 3 ACCESS cycles -> psel = penable = 1 for 4 cycles; paddr/pwdata constant throughout.
- AWLEN = 3 -> cmd_err = 1; all 4 W beats accepted until WLAST; one APB write with pstrb = 0.
- ARVALID and AWVALID both high for two consecutive commands -> read granted first, write second (round-robin).
- rstn pulsed low during ACCESS -> psel = penable = 0 immediately; IDLE with ARREADY high after release.
